// File: rtl/run_sequencer.sv
// Run sequencer: holds a datapath in reset, releases it, and times the run until OUT matches.
// Optional timeout abort is enabled by defining RUN_SEQUENCER_TIMEOUT_EN.
module run_sequencer #(
    parameter int          RESET_CYCLES = 4,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] run_in,
    input  logic [15:0] expected,
    input  logic [15:0] dp_out,
    input  logic [15:0] dp_instr,
    output logic        dp_reset,
    output logic [15:0] dp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [15:0] cycle_count,
    output logic [15:0] instr_count
);

    localparam int              RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0]   RST_LAST = RW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RESET_DP, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   op_q;
    logic [15:0]   exp_q;
    logic [15:0]   counter;
    logic [RW-1:0] rst_cnt;
    logic          match;
    logic          expire;

    assign match = (state == RUN) && (dp_out == exp_q);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
    logic timed_out_q;
    // A match in the same cycle as the timeout takes priority.
    assign expire    = (state == RUN) && (counter == TIMEOUT) && !match;
    assign timed_out = timed_out_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign timed_out      = 1'b0;
`endif

    assign dp_reset = (state != RUN);
    assign busy     = (state == RESET_DP) || (state == RUN);
    assign done     = (state == DONE);
    assign dp_in    = op_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = RESET_DP;
            RESET_DP: if (rst_cnt == RST_LAST) state_nxt = RUN;
            RUN:      if (match || expire) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: op_q is reset because dp_in must read 0 until the first start.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            exp_q       <= '0;
            counter     <= '0;
            rst_cnt     <= '0;
            pass        <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
            timed_out_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= run_in;
                        exp_q   <= expected;
                        counter <= '0;
                        rst_cnt <= '0;
                    end
                end
                RESET_DP: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RST_LAST) counter <= 16'd1;
                end
                RUN: begin
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                    counter <= counter + 16'd1;
`else
                    if (counter != 16'hFFFF) counter <= counter + 16'd1;
`endif
                    if (match) begin
                        pass        <= 1'b1;
                        cycle_count <= counter;
                        instr_count <= dp_instr;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                        timed_out_q <= 1'b0;
`endif
                    end else if (expire) begin
                        pass        <= 1'b0;
                        cycle_count <= TIMEOUT;
                        instr_count <= dp_instr;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
                        timed_out_q <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a stub datapath and a result scoreboard.
// Timeout scenarios run only when RUN_SEQUENCER_TIMEOUT_EN is defined for the build.
module tb_run_sequencer;

    localparam int RST_CYC = 4;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] run_in;
    logic [15:0] expected;
    logic [15:0] dp_out;
    logic [15:0] dp_instr;
    logic        dp_reset;
    logic [15:0] dp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        pass;
        logic        to;
        logic [15:0] cc;
        logic [15:0] ic;
    } exp_t;

    exp_t sb[$];

    // Stub datapath: counts cycles since its reset was released.
    int          stub_cyc;
    int          match_cycle;
    logic [15:0] match_val;
    logic [15:0] instr_val;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n)      stub_cyc <= 0;
        else if (dp_reset) stub_cyc <= 0;
        else               stub_cyc <= stub_cyc + 1;
    end

    assign dp_out   = (match_cycle != 0 && stub_cyc + 1 == match_cycle) ? match_val : ~match_val;
    assign dp_instr = instr_val;

    always #5 CLK = ~CLK;

    run_sequencer #(.RESET_CYCLES(RST_CYC), .TIMEOUT(16'd100)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .start       (start),
        .run_in      (run_in),
        .expected    (expected),
        .dp_out      (dp_out),
        .dp_instr    (dp_instr),
        .dp_reset    (dp_reset),
        .dp_in       (dp_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timed_out   (timed_out),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge in IDLE; drives one run and checks its result via the scoreboard.
    task automatic do_run(input logic [15:0] op, input logic [15:0] ev, input int mcyc,
                          input logic [15:0] instr, input int budget, input logic exp_pass,
                          input logic exp_to, input logic [15:0] exp_cc, input bit start_in_done);
        exp_t e;
        int   rst_hi;
        int   run_cyc;
        bit   seen;
        bit   op_ok;
        match_cycle = mcyc;
        match_val   = ev;
        instr_val   = instr;
        sb.push_back('{pass: exp_pass, to: exp_to, cc: exp_cc, ic: instr});
        start    = 1'b1;
        run_in   = op;
        expected = ev;
        @(negedge CLK);
        start    = 1'b0;
        run_in   = ~op;
        expected = ~ev;
        rst_hi = 0;
        op_ok  = 1'b1;
        while (busy && dp_reset && rst_hi < 50) begin
            rst_hi++;
            if (dp_in !== op) op_ok = 1'b0;
            @(negedge CLK);
        end
        check("reset_dp_cycles", rst_hi, RST_CYC);
        check("dp_in_in_reset_dp", 32'(op_ok), 1);
        run_cyc = 0;
        seen    = 1'b0;
        while (!seen && run_cyc < budget) begin
            if (done) seen = 1'b1;
            else begin
                if (busy && !dp_reset) run_cyc++;
                @(negedge CLK);
            end
        end
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            if (start_in_done) start = 1'b1;
            e = sb.pop_front();
            check("done_dp_reset", dp_reset, 1);
            check("pass", pass, e.pass);
            check("timed_out", timed_out, e.to);
            check("cycle_count", cycle_count, e.cc);
            check("instr_count", instr_count, e.ic);
            check("run_cycles", run_cyc, 32'(e.cc));
            @(negedge CLK);
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("idle_not_busy", busy, 0);
            check("dp_in_hold", dp_in, op);
            @(negedge CLK);
            check("pass_hold", pass, e.pass);
            check("cycle_count_hold", cycle_count, e.cc);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_glitch;
        reset_n     = 1'b0;
        start       = 1'b0;
        run_in      = 16'h0;
        expected    = 16'h0;
        match_cycle = 0;
        match_val   = 16'h0;
        instr_val   = 16'h0;
        repeat (2) @(negedge CLK);
        check("rst_dp_reset", dp_reset, 1);
        check("rst_dp_in", dp_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_instr_count", instr_count, 0);
        reset_n = 1'b1;
        @(negedge CLK);
        check("idle_dp_reset", dp_reset, 1);

        do_run(16'h13b0, 16'd11, 20, 16'd37, 200, 1'b1, 1'b0, 16'd20, 1'b0);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
        do_run(16'h2222, 16'h00aa, 0, 16'd5, 300, 1'b0, 1'b1, 16'd100, 1'b0);
        do_run(16'h3333, 16'h00bb, 100, 16'd6, 300, 1'b1, 1'b0, 16'd100, 1'b0);
`else
        do_run(16'h2222, 16'h00aa, 150, 16'd5, 300, 1'b1, 1'b0, 16'd150, 1'b0);
`endif

        do_run(16'h0906, 16'd13, 8, 16'd21, 200, 1'b1, 1'b0, 16'd8, 1'b1);
        do_run(16'h7540, 16'd17, 15, 16'd44, 200, 1'b1, 1'b0, 16'd15, 1'b0);

        match_cycle = 0;
        match_val   = 16'h1234;
        start       = 1'b1;
        run_in      = 16'h55aa;
        expected    = 16'h1234;
        @(negedge CLK);
        start = 1'b0;
        repeat (RST_CYC + 5) @(negedge CLK);
        check("midrun_in_run", dp_reset, 0);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("start_ignored_busy", busy, 1);
        check("start_ignored_dp_reset", dp_reset, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_dp_reset", dp_reset, 1);
        check("async_busy", busy, 0);
        check("async_dp_in", dp_in, 0);
        done_glitch = 1'b0;
        repeat (3) begin
            if (done) done_glitch = 1'b1;
            @(negedge CLK);
        end
        reset_n = 1'b1;
        repeat (3) begin
            if (done) done_glitch = 1'b1;
            @(negedge CLK);
        end
        check("abort_no_done", 32'(done_glitch), 0);
        check("abort_pass_cleared", pass, 0);
        check("abort_cycle_count_cleared", cycle_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_CYCLES, default 4, SHALL set the number of cycles dp_reset is held high before a run.
REQ-003 Parameter TIMEOUT, default 16'hFFFF, SHALL set the maximum number of RUN cycles before abort.
REQ-004 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a run; it SHALL be honoured only in IDLE.
REQ-007 run_in  input  16  operand applied to the datapath IN port.
REQ-008 expected  input  16  datapath OUT value that signals completion.
REQ-009 dp_out  input  16  datapath OUT.
REQ-010 dp_instr  input  16  datapath numInstructionsExecuted.
REQ-011 dp_reset  output  1  active-high reset to the datapath.
REQ-012 dp_in  output  16  drives the datapath IN port.
REQ-013 busy  output  1  high in RESET_DP and RUN.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  last run matched expected.
REQ-016 timed_out  output  1  last run aborted on timeout.
REQ-017 cycle_count  output  16  RUN cycles taken by the last run.
REQ-018 instr_count  output  16  dp_instr captured at the end of the last run.

Function
REQ-019 The state machine SHALL have the states IDLE, RESET_DP, RUN and DONE.
REQ-020 IDLE: dp_reset SHALL be 1; on start, the block SHALL latch run_in and expected, clear the internal counter, and go to RESET_DP.
REQ-021 RESET_DP: dp_reset SHALL be 1 and dp_in SHALL equal the latched operand for exactly RESET_CYCLES cycles; the block SHALL then go to RUN.
REQ-022 RUN: dp_reset SHALL be 0; the counter SHALL equal 1 in the first RUN cycle and increment by 1 each RUN cycle.
REQ-023 When dp_out equals the latched expected value during a RUN cycle, the next edge SHALL enter DONE with pass=1, timed_out=0, cycle_count=counter and instr_count=dp_instr, all sampled in that cycle.
REQ-024 When the counter equals TIMEOUT without a match, the next edge SHALL enter DONE with pass=0, timed_out=1 and cycle_count=TIMEOUT.
REQ-025 If a match and a timeout occur in the same cycle, the match SHALL win.
REQ-026 DONE SHALL last exactly one cycle with done=1 and dp_reset=1, then return to IDLE.
REQ-027 pass, timed_out, cycle_count and instr_count SHALL hold their values until the next DONE.
REQ-028 start while busy or in DONE SHALL be ignored; run_in and expected changes during a run SHALL have no effect.
REQ-029 dp_in SHALL hold the latched operand in every state after the first start.

Reset
REQ-030 While reset_n=0, outputs SHALL be: state=IDLE, dp_reset=1, dp_in=0, busy=0, done=0, pass=0, timed_out=0, cycle_count=0, instr_count=0.
REQ-031 Asserting reset_n mid-run SHALL abort the run immediately and SHALL NOT pulse done.

Configuration
REQ-032 The macro RUN_SEQUENCER_TIMEOUT_EN SHALL control the timeout feature.
REQ-033 With RUN_SEQUENCER_TIMEOUT_EN defined, REQ-024 and REQ-025 SHALL apply.
REQ-034 Without RUN_SEQUENCER_TIMEOUT_EN, RUN SHALL wait indefinitely for a match, timed_out SHALL be tied to 0, and the counter SHALL saturate at 16'hFFFF.

Verification
REQ-035 The bench SHALL use a stub datapath and SHALL cover the following scenarios:
- Hold reset_n=0 -> all outputs at the REQ-030 values; dp_reset=1.
- start with run_in=16'h13b0, expected=11; stub drives dp_out=11 in RUN cycle 20 and dp_instr=37 -> dp_reset high for 4 cycles, dp_in=16'h13b0, done pulses once, pass=1, cycle_count=20, instr_count=37.
- TIMEOUT=100, macro defined, dp_out never matches -> done after RUN cycle 100, timed_out=1, pass=0, cycle_count=100.
- TIMEOUT=100, match in RUN cycle 100 -> pass=1, timed_out=0, cycle_count=100.
- start pulsed in RUN, then reset_n=0 mid-RUN -> start ignored; dp_reset=1 and busy=0 asynchronously; no done pulse.
- Back-to-back runs 16'h0906/13 (match at cycle 8), then 16'h7540/17 (match at cycle 15) -> cycle_count 8 then 15; counter restarts per run.
